serial_complement_ctrl: RTL and testbench

// - Shares one bit-serial two's-complement engine between two requesters.
// - The engine is a single half-adder cell with a registered carry.
// - Each requester submits a WIDTH-bit operand and an op code (negate or absolute value).
//   A round-robin arbiter grants one request at a time.
// - The operand is processed LSB-first, one bit per clock.
// - The result is returned on a valid/ready output channel, with a requester tag and an

---
 rtl/serial_complement_pkg.sv | 13 +
 rtl/serial_complement_half_adder.sv | 12 +
 rtl/serial_complement_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_serial_complement_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_complement_pkg.sv
// Shared types and op codes for the bit-serial two's-complement controller.
package serial_complement_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sc_state_t;

  localparam logic OP_NEG = 1'b0;
  localparam logic OP_ABS = 1'b1;

endpackage

// File: rtl/serial_complement_half_adder.sv
// Single half-adder cell: the only arithmetic element of the serial complement engine.
module serial_complement_half_adder (
  input  logic a,
  input  logic carry_in,
  output logic carry_out,
  output logic out
);

  assign out       = a ^ carry_in;
  assign carry_out = a & carry_in;

endmodule

// File: rtl/serial_complement_ctrl.sv
// Two-requester round-robin front end around one bit-serial two's-complement engine.
// Results leave on a valid/ready channel tagged with the owning requester.
module serial_complement_ctrl
  import serial_complement_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_tag,
  output logic             res_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  sc_state_t        r_state;
  sc_state_t        w_next_state;
  logic             r_ptr;
  logic             w_grant1;
  logic             w_accept;
  logic             w_sel_op;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_inv;
  logic             w_last;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_res;
  logic             r_inv;
  logic             r_carry;
  logic             r_tag;
  logic             r_ovf;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_a;
  logic             w_sum;
  logic             w_carry_out;

  // r_ptr names the requester favoured when both are valid
  always_comb begin
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant1 = r_ptr;
    end else if (req1_valid) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant1 = 1'b0;
    end
  end

  assign w_sel_data = w_grant1 ? req1_data : req0_data;
  assign w_sel_op   = w_grant1 ? req1_op : req0_op;
  assign w_inv      = (w_sel_op == OP_NEG) | w_sel_data[WIDTH-1];
  assign w_accept   = req0_ready | req1_ready;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a        = r_shift[0] ^ r_inv;

  serial_complement_half_adder u_ha (
    .a         (w_a),
    .carry_in  (r_carry),
    .carry_out (w_carry_out),
    .out       (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = req0_valid & ~w_grant1;
        req1_ready = req1_valid & w_grant1;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant1;
    end
  end

  // Carry is preloaded with inv so the first bit receives the +1 of the complement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_res   <= '0;
      r_inv   <= 1'b0;
      r_carry <= 1'b0;
      r_tag   <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= w_sel_data;
            r_tag   <= w_grant1;
            r_inv   <= w_inv;
            r_carry <= w_inv;
            r_ovf   <= w_inv & (w_sel_data == MIN_NEG);
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_shift <= r_shift >> 1;
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_res;
  assign res_tag   = r_tag;
  assign res_ovf   = r_ovf;

endmodule

// File: tb/tb_serial_complement_ctrl.sv
// Self-checking bench for serial_complement_ctrl: directed table, contention, stall,
// reset-in-flight and randomized operations against an arithmetic reference model.
module tb_serial_complement_ctrl;
  import serial_complement_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_op;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req0_data, req1_data;
  logic         res_valid, res_ready, res_tag, res_ovf;
  logic [W-1:0] res_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         who;
    logic [7:0] d;
    logic       op;
    logic [7:0] exp_d;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[6];

  serial_complement_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .res_ovf    (res_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: mathematical negate / absolute value, truncated to 8 bits
  task automatic model(input logic [7:0] x, input logic op, output logic [7:0] r, output logic ovf);
    int v;
    int m;
    v = int'($signed(x));
    if (op == OP_NEG) m = -v;
    else m = (v < 0) ? -v : v;
    r   = m[7:0];
    ovf = (m > 127);
  endtask

  task automatic wait_ready(input int who, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) got = 1'b1;
    end
  endtask

  // Called just after an accept edge; returns edges until res_valid is seen (0 = timeout)
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) lat = i;
    end
  endtask

  task automatic release_result(input string nm);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({nm, " valid_drop"}, res_valid, 1'b0);
  endtask

  task automatic run_op(input int who, input logic [7:0] d, input logic op,
                        input logic [7:0] exp_d, input logic exp_ovf, input int stall,
                        input string nm);
    bit got;
    int lat;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (who == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_op = op;
    end
    wait_ready(who, got);
    chk({nm, " ready"}, got, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_valid(lat);
    chk({nm, " latency"}, lat, 8);
    chk({nm, " data"}, res_data, exp_d);
    chk({nm, " tag"}, res_tag, who[0]);
    chk({nm, " ovf"}, res_ovf, exp_ovf);
    repeat (stall) @(negedge clk);
    chk({nm, " held"}, {res_valid, res_data}, {1'b1, exp_d});
    release_result(nm);
  endtask

  initial begin
    int grants[4];
    int ngr, nres, both_err, dbl_err, stab_err, lat, prev_rdy;
    bit got;
    logic [7:0] ed;
    logic eo;

    tbl[0] = '{0, 8'h05, OP_NEG, 8'hFB, 1'b0};
    tbl[1] = '{0, 8'h80, OP_NEG, 8'h80, 1'b1};
    tbl[2] = '{0, 8'h00, OP_NEG, 8'h00, 1'b0};
    tbl[3] = '{0, 8'h80, OP_ABS, 8'h80, 1'b1};
    tbl[4] = '{1, 8'hF6, OP_ABS, 8'h0A, 1'b0};
    tbl[5] = '{1, 8'h3C, OP_ABS, 8'h3C, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_op = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_op = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {res_valid, res_data, res_tag, res_ovf}, 11'h000);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention right after reset: alternate 0,1,0,1 with single-cycle readies
    @(posedge clk); #1;
    res_ready = 1'b1;
    req0_data = 8'h11; req0_op = OP_NEG;
    req1_data = 8'hF0; req1_op = OP_ABS;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ngr = 0; nres = 0; both_err = 0; dbl_err = 0; prev_rdy = 0;
    for (int c = 0; c < 200 && nres < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both_err++;
      if ((req0_ready || req1_ready) && prev_rdy != 0) dbl_err++;
      prev_rdy = (req0_ready || req1_ready) ? 1 : 0;
      if (res_valid && nres < ngr) begin
        chk("contend tag", res_tag, grants[nres][0]);
        chk("contend data", res_data, (grants[nres] == 0) ? 8'hEF : 8'h10);
        nres++;
      end
      if (ngr < 4 && (req0_ready || req1_ready)) begin
        grants[ngr] = req1_ready ? 1 : 0;
        ngr++;
        if (ngr == 4) begin
          @(posedge clk); #1;
          req0_valid = 1'b0; req1_valid = 1'b0;
          prev_rdy = 0;
        end
      end
    end
    chk("contend grants", ngr, 4);
    chk("contend results", nres, 4);
    for (int i = 0; i < 4; i++) chk("contend order", grants[i], i % 2);
    chk("contend both_ready", both_err, 0);
    chk("contend ready_pulse", dbl_err, 0);
    @(posedge clk); #1;
    res_ready = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].who, tbl[i].d, tbl[i].op, tbl[i].exp_d, tbl[i].exp_ovf, 0, "table");

    for (int i = 0; i < 20; i++) begin
      int who;
      logic [7:0] d;
      logic op;
      who = $urandom_range(0, 1);
      d   = 8'($urandom);
      op  = 1'($urandom_range(0, 1));
      model(d, op, ed, eo);
      run_op(who, d, op, ed, eo, $urandom_range(0, 3), "random");
    end

    // Stall in DONE with both valids high; accept follows the result handshake
    @(posedge clk); #1;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h05; req0_op = OP_NEG;
    wait_ready(0, got);
    chk("stall ready", got, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 8'h3C; req1_op = OP_ABS;
    wait_valid(lat);
    chk("stall latency", lat, 8);
    stab_err = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if ({res_valid, res_data, res_tag, res_ovf} !== {1'b1, 8'hFB, 1'b0, 1'b0}) stab_err++;
      if (req0_ready || req1_ready) stab_err++;
    end
    chk("stall stable", stab_err, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("handshake no_ready", {req0_ready, req1_ready, res_valid}, 3'b001);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_handshake grant", {res_valid, req0_ready, req1_ready}, 3'b001);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_valid(lat);
    chk("stall2 latency", lat, 8);
    chk("stall2 result", {res_data, res_tag, res_ovf}, {8'h3C, 1'b1, 1'b0});
    release_result("stall2");

    // Reset in flight at SHIFT count 3 after a req0 grant
    @(posedge clk); #1;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h37; req0_op = OP_NEG;
    wait_ready(0, got);
    chk("rst_mid ready", got, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid valid", res_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    stab_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) stab_err++;
    end
    chk("rst_mid no_result", stab_err, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'hC8; req0_op = OP_ABS;
    req1_valid = 1'b1; req1_data = 8'h01; req1_op = OP_NEG;
    @(negedge clk);
    chk("rst_mid grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_valid(lat);
    model(8'hC8, OP_ABS, ed, eo);
    chk("rst_mid latency", lat, 8);
    chk("rst_mid result", {res_data, res_tag, res_ovf}, {ed, 1'b0, eo});
    release_result("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
